multicycle_ctrl: RTL and testbench

//  Multi-cycle sequencer for the LEGv8-subset datapath (ADD, SUB, LDUR, STUR, B, CBZ).

---
 rtl/multicycle_ctrl_pkg.sv | 42 ++++
 rtl/multicycle_ctrl_if.sv | 11 +
 rtl/multicycle_ctrl_instr_decode.sv | 37 +++
 rtl/multicycle_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and constants for the LEGv8-subset multi-cycle controller.
package multicycle_ctrl_pkg;

   typedef enum logic [2:0] {BOOT, FETCH, DECODE, EXEC, MEM, WB, HALT} ctrl_state_t;

   typedef enum logic [2:0] {
      IC_ILLEGAL, IC_ADD, IC_SUB, IC_LDUR, IC_STUR, IC_B, IC_CBZ
   } instr_class_t;

   typedef enum logic [1:0] {
      FAULT_NONE    = 2'b00,
      FAULT_ILLEGAL = 2'b01,
      FAULT_TIMEOUT = 2'b10
   } fault_t;

   // Opcode patterns/masks over instr[31:21]
   localparam logic [10:0] OPC_ADD  = 11'b10001011000;
   localparam logic [10:0] OPC_SUB  = 11'b11001011000;
   localparam logic [10:0] OPC_LDUR = 11'b11111000010;
   localparam logic [10:0] OPC_STUR = 11'b11111000000;
   localparam logic [10:0] OPC_B    = 11'b00010100000;
   localparam logic [10:0] MASK_B   = 11'b11111100000;
   localparam logic [10:0] OPC_CBZ  = 11'b10110100000;
   localparam logic [10:0] MASK_CBZ = 11'b11111111000;

   localparam logic [2:0] ALU_PASS_B = 3'b000;
   localparam logic [2:0] ALU_ADD    = 3'b010;
   localparam logic [2:0] ALU_SUB    = 3'b011;

   typedef struct packed {
      instr_class_t cls;
      logic         reg2loc;
      logic         alu_src;
      logic         mem_to_reg;
      logic [2:0]   alu_op;
   } decode_t;

   function automatic logic op_match(logic [10:0] opc, logic [10:0] pat, logic [10:0] mask);
      return (opc & mask) == pat;
   endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Instruction/data memory request-ready handshake bundle.
interface multicycle_ctrl_if;
   logic        imem_req;
   logic        imem_ready;
   logic [31:0] instr;
   logic        dmem_req;
   logic        dmem_ready;

   modport master (output imem_req, dmem_req, input imem_ready, dmem_ready, instr);
   modport slave  (input imem_req, dmem_req, output imem_ready, dmem_ready, instr);
endinterface

// File: rtl/multicycle_ctrl_instr_decode.sv
// Combinational opcode classifier producing the per-instruction static selects.
module instr_decode
   import multicycle_ctrl_pkg::*;
(
   input  logic [10:0] opcode,
   output decode_t     dec
);

   always_comb begin
      dec        = '0;
      dec.cls    = IC_ILLEGAL;
      dec.alu_op = ALU_PASS_B;
      if (opcode == OPC_ADD) begin
         dec.cls     = IC_ADD;
         dec.reg2loc = 1'b1;
         dec.alu_op  = ALU_ADD;
      end else if (opcode == OPC_SUB) begin
         dec.cls     = IC_SUB;
         dec.reg2loc = 1'b1;
         dec.alu_op  = ALU_SUB;
      end else if (opcode == OPC_LDUR) begin
         dec.cls        = IC_LDUR;
         dec.alu_src    = 1'b1;
         dec.mem_to_reg = 1'b1;
         dec.alu_op     = ALU_ADD;
      end else if (opcode == OPC_STUR) begin
         dec.cls     = IC_STUR;
         dec.alu_src = 1'b1;
         dec.alu_op  = ALU_ADD;
      end else if (op_match(opcode, OPC_B, MASK_B)) begin
         dec.cls = IC_B;
      end else if (op_match(opcode, OPC_CBZ, MASK_CBZ)) begin
         dec.cls = IC_CBZ;
      end
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer: FSM, decode latch, memory-wait timeout.
// Optional PERF_CNT_EN adds cycle/retire counters.
module multicycle_ctrl
   import multicycle_ctrl_pkg::*;
#(
   parameter int unsigned ALUOP_W     = 3,
   parameter int unsigned MEM_TIMEOUT = 15,
   parameter int unsigned CNT_W       = 32
) (
   input  logic               clk,
   input  logic               reset,
   multicycle_ctrl_if.master  mem,
   input  logic               zero,
   output logic               ir_load,
   output logic               pc_write,
   output logic               reg2loc,
   output logic               alu_src,
   output logic               mem_to_reg,
   output logic               uncond_br,
   output logic               br_taken,
   output logic               reg_write,
   output logic               mem_write,
   output logic [ALUOP_W-1:0] alu_op,
   output logic               halted,
   output logic [1:0]         fault
`ifdef PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]   cyc_cnt,
   output logic [CNT_W-1:0]   ret_cnt
`endif
);

   localparam int unsigned WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

   ctrl_state_t       state_q, state_d;
   decode_t           dec_q, dec_d, dec_new;
   fault_t            fault_q, fault_d;
   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic              timeout_hit;

   instr_decode u_decode (
      .opcode (mem.instr[31:21]),
      .dec    (dec_new)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= BOOT;
         dec_q      <= '0;
         fault_q    <= FAULT_NONE;
         wait_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         dec_q      <= dec_d;
         fault_q    <= fault_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   always_comb begin
      timeout_hit = (MEM_TIMEOUT != 0) && (wait_cnt_q == WAIT_W'(MEM_TIMEOUT - 1));
   end

   always_comb begin
      state_d    = state_q;
      dec_d      = dec_q;
      fault_d    = fault_q;
      wait_cnt_d = wait_cnt_q;
      unique case (state_q)
         BOOT:   state_d = FETCH;
         FETCH: begin
            if (mem.imem_ready) begin
               dec_d   = dec_new;
               state_d = DECODE;
            end else if (timeout_hit) begin
               fault_d = FAULT_TIMEOUT;
               state_d = HALT;
            end else begin
               wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end
         end
         DECODE: begin
            if (dec_q.cls == IC_ILLEGAL) begin
               fault_d = FAULT_ILLEGAL;
               state_d = HALT;
            end else begin
               state_d = EXEC;
            end
         end
         EXEC: begin
            unique case (dec_q.cls)
               IC_ADD, IC_SUB:   state_d = WB;
               IC_LDUR, IC_STUR: state_d = MEM;
               default:          state_d = FETCH;
            endcase
         end
         MEM: begin
            if (mem.dmem_ready) begin
               state_d = (dec_q.cls == IC_LDUR) ? WB : FETCH;
            end else if (timeout_hit) begin
               fault_d = FAULT_TIMEOUT;
               state_d = HALT;
            end else begin
               wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end
         end
         WB:      state_d = FETCH;
         default: state_d = HALT;
      endcase
      // Any state change (only ever into FETCH/MEM matters) restarts the wait window
      if (state_d != state_q) wait_cnt_d = '0;
   end

   always_comb begin
      mem.imem_req = 1'b0;
      mem.dmem_req = 1'b0;
      ir_load      = 1'b0;
      pc_write     = 1'b0;
      reg2loc      = 1'b0;
      alu_src      = 1'b0;
      mem_to_reg   = 1'b0;
      uncond_br    = 1'b0;
      br_taken     = 1'b0;
      reg_write    = 1'b0;
      mem_write    = 1'b0;
      alu_op       = '0;
      halted       = (state_q == HALT);
      fault        = fault_q;
      if (state_q inside {DECODE, EXEC, MEM, WB}) begin
         reg2loc    = dec_q.reg2loc;
         alu_src    = dec_q.alu_src;
         mem_to_reg = dec_q.mem_to_reg;
         alu_op     = ALUOP_W'(dec_q.alu_op);
      end
      unique case (state_q)
         FETCH: begin
            mem.imem_req = 1'b1;
            ir_load      = mem.imem_ready;
         end
         EXEC: begin
            if (dec_q.cls == IC_B) begin
               pc_write  = 1'b1;
               br_taken  = 1'b1;
               uncond_br = 1'b1;
            end else if (dec_q.cls == IC_CBZ) begin
               pc_write = 1'b1;
               br_taken = zero;
            end
         end
         MEM: begin
            mem.dmem_req = 1'b1;
            mem_write    = (dec_q.cls == IC_STUR);
            pc_write     = mem.dmem_ready && (dec_q.cls == IC_STUR);
         end
         WB: begin
            reg_write = 1'b1;
            pc_write  = 1'b1;
         end
         default: ;
      endcase
   end

`ifdef PERF_CNT_EN
   logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d, ret_cnt_q, ret_cnt_d;

   always_comb begin
      cyc_cnt_d = cyc_cnt_q;
      ret_cnt_d = ret_cnt_q;
      if (state_q != BOOT && state_q != HALT) cyc_cnt_d = cyc_cnt_q + CNT_W'(1);
      if (pc_write) ret_cnt_d = ret_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cyc_cnt_q <= '0;
         ret_cnt_q <= '0;
      end else begin
         cyc_cnt_q <= cyc_cnt_d;
         ret_cnt_q <= ret_cnt_d;
      end
   end

   always_comb begin
      cyc_cnt = cyc_cnt_q;
      ret_cnt = ret_cnt_q;
   end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench: builds a per-cycle stimulus/expected-output schedule from
// instruction-level rules, then replays it against the controller.
module tb_multicycle_ctrl;

   localparam int unsigned CNT_W = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        zero = 1'b0;
   logic        ir_load, pc_write, reg2loc, alu_src, mem_to_reg, uncond_br;
   logic        br_taken, reg_write, mem_write, halted;
   logic [2:0]  alu_op;
   logic [1:0]  fault;
   logic [16:0] obs;
`ifdef PERF_CNT_EN
   logic [CNT_W-1:0] cyc_cnt, ret_cnt;
`endif

   multicycle_ctrl_if mem_if ();

   multicycle_ctrl #(.ALUOP_W(3), .MEM_TIMEOUT(15), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .mem        (mem_if.master),
      .zero       (zero),
      .ir_load    (ir_load),
      .pc_write   (pc_write),
      .reg2loc    (reg2loc),
      .alu_src    (alu_src),
      .mem_to_reg (mem_to_reg),
      .uncond_br  (uncond_br),
      .br_taken   (br_taken),
      .reg_write  (reg_write),
      .mem_write  (mem_write),
      .alu_op     (alu_op),
      .halted     (halted),
      .fault      (fault)
`ifdef PERF_CNT_EN
      ,
      .cyc_cnt    (cyc_cnt),
      .ret_cnt    (ret_cnt)
`endif
   );

   always #5 clk = ~clk;

   always_comb begin
      obs = {mem_if.imem_req, mem_if.dmem_req, ir_load, pc_write, reg2loc, alu_src,
             mem_to_reg, uncond_br, br_taken, reg_write, mem_write, alu_op, halted, fault};
   end

   localparam logic [16:0] O_IREQ = 17'h10000, O_DREQ = 17'h08000, O_IRLD = 17'h04000;
   localparam logic [16:0] O_PCW  = 17'h02000, O_R2L  = 17'h01000, O_ASRC = 17'h00800;
   localparam logic [16:0] O_M2R  = 17'h00400, O_UNC  = 17'h00200, O_BRT  = 17'h00100;
   localparam logic [16:0] O_RW   = 17'h00080, O_MW   = 17'h00040, O_HALT = 17'h00004;
   localparam logic [16:0] O_ALU_ADD = 17'h00010, O_ALU_SUB = 17'h00018;

   localparam int C_ILL = 0, C_ADD = 1, C_SUB = 2, C_LDUR = 3, C_STUR = 4, C_B = 5, C_CBZ = 6;

   typedef struct {
      bit          rst;
      bit          ir;
      bit          dr;
      bit          z;
      logic [31:0] ins;
      logic [16:0] exp;
      bit          act;
   } cyc_t;

   cyc_t sched[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic bit rbit();
      return 1'($urandom_range(0, 1));
   endfunction

   // ir/dr/zv: 0 or 1 drives that value, 2 drives a random value
   function automatic void push(int ir, int dr, int zv, logic [31:0] iv, logic [16:0] e, bit act);
      cyc_t c;
      c.rst = 1'b0;
      c.ir  = (ir == 2) ? rbit() : ir[0];
      c.dr  = (dr == 2) ? rbit() : dr[0];
      c.z   = (zv == 2) ? rbit() : zv[0];
      c.ins = iv;
      c.exp = e;
      c.act = act;
      sched.push_back(c);
   endfunction

   function automatic void do_reset();
      sched[sched.size() - 1].rst = 1'b1;
      push(2, 2, 2, $urandom, '0, 1'b0);
   endfunction

   function automatic int cls_of(logic [31:0] i);
      if (i[31:21] == 11'b10001011000) return C_ADD;
      if (i[31:21] == 11'b11001011000) return C_SUB;
      if (i[31:21] == 11'b11111000010) return C_LDUR;
      if (i[31:21] == 11'b11111000000) return C_STUR;
      if (i[31:26] == 6'b000101)       return C_B;
      if (i[31:24] == 8'b10110100)     return C_CBZ;
      return C_ILL;
   endfunction

   function automatic logic [16:0] sel_of(int c);
      case (c)
         C_ADD:   return O_R2L | O_ALU_ADD;
         C_SUB:   return O_R2L | O_ALU_SUB;
         C_LDUR:  return O_ASRC | O_M2R | O_ALU_ADD;
         C_STUR:  return O_ASRC | O_ALU_ADD;
         default: return '0;
      endcase
   endfunction

   function automatic logic [31:0] rand_instr(int c);
      logic [31:0] w;
      w = $urandom;
      case (c)
         C_ADD:  w = {11'b10001011000, w[20:0]};
         C_SUB:  w = {11'b11001011000, w[20:0]};
         C_LDUR: w = {11'b11111000010, w[20:0]};
         C_STUR: w = {11'b11111000000, w[20:0]};
         C_B:    w = {6'b000101, w[25:0]};
         C_CBZ:  w = {8'b10110100, w[23:0]};
         default: if (cls_of(w) != C_ILL) w = 32'hFFFF_FFFF;
      endcase
      return w;
   endfunction

   function automatic int pick_dly();
      int r;
      r = int'($urandom_range(0, 19));
      if (r < 11) return 0;
      if (r < 17) return int'($urandom_range(1, 4));
      if (r == 17) return 14;
      if (r == 18) return 15;
      return 20;
   endfunction

   // Expected cycles for one instruction: ready after idly/ddly waiting cycles,
   // a wait of 15 or more cycles is a timeout; abort_at >= 0 resets on that cycle.
   function automatic void gen(logic [31:0] ins, int idly, int ddly, bit z, int abort_at);
      int          base;
      int          c;
      logic [16:0] s;
      logic [16:0] mw;
      bit          hlt;
      logic [1:0]  f;
      base = sched.size();
      c    = cls_of(ins);
      s    = sel_of(c);
      hlt  = 1'b0;
      f    = 2'b00;
      for (int i = 0; i < idly && i < 15; i++) push(0, 2, 2, $urandom, O_IREQ, 1'b1);
      if (idly >= 15) begin
         hlt = 1'b1;
         f   = 2'b10;
      end else begin
         push(1, 2, 2, ins, O_IREQ | O_IRLD, 1'b1);
         push(2, 2, 2, $urandom, s, 1'b1);
         if (c == C_ILL) begin
            hlt = 1'b1;
            f   = 2'b01;
         end else begin
            if (c == C_B)        push(2, 2, 2, $urandom, s | O_PCW | O_BRT | O_UNC, 1'b1);
            else if (c == C_CBZ) push(2, 2, int'(z), $urandom, s | O_PCW | (z ? O_BRT : 17'h0), 1'b1);
            else                 push(2, 2, 2, $urandom, s, 1'b1);
            if (c == C_LDUR || c == C_STUR) begin
               mw = (c == C_STUR) ? O_MW : 17'h0;
               for (int i = 0; i < ddly && i < 15; i++) push(2, 0, 2, $urandom, s | O_DREQ | mw, 1'b1);
               if (ddly >= 15) begin
                  hlt = 1'b1;
                  f   = 2'b10;
               end else begin
                  push(2, 1, 2, $urandom, s | O_DREQ | mw | ((c == C_STUR) ? O_PCW : 17'h0), 1'b1);
               end
            end
            if (!hlt && (c == C_ADD || c == C_SUB || c == C_LDUR))
               push(2, 2, 2, $urandom, s | O_RW | O_PCW, 1'b1);
         end
      end
      if (hlt) for (int i = 0; i < 3; i++) push(2, 2, 2, $urandom, O_HALT | {15'h0, f}, 1'b0);
      if (abort_at >= 0 && abort_at < sched.size() - base) begin
         while (sched.size() > base + abort_at + 1) void'(sched.pop_back());
         do_reset();
      end else if (hlt) begin
         do_reset();
      end
   endfunction

   initial begin
      int          c;
      int          ab;
      logic [31:0] m_cyc;
      logic [31:0] m_ret;
      mem_if.imem_ready = 1'b0;
      mem_if.dmem_ready = 1'b0;
      mem_if.instr      = '0;

      push(0, 0, 0, '0, '0, 1'b0);
      do_reset();
      gen(32'h8B020020, 0, 0, 1'b0, -1);
      gen(32'hF8400041, 0, 3, 1'b0, -1);
      gen(32'hB4000040, 0, 0, 1'b1, -1);
      gen(32'hB4000040, 0, 0, 1'b0, -1);
      gen(32'h14000004, 0, 0, 1'b0, -1);
      gen(32'hF8000041, 0, 2, 1'b0, -1);
      gen(32'hFFFFFFFF, 0, 0, 1'b0, -1);
      gen(32'h8B020020, 20, 0, 1'b0, -1);
      gen(32'hCB020020, 14, 0, 1'b0, -1);
      gen(32'hF8400041, 2, 14, 1'b0, -1);
      gen(32'hF8000041, 0, 15, 1'b0, -1);
      gen(32'hF8000041, 0, 5, 1'b0, 4);
      for (int n = 0; n < 250; n++) begin
         c  = int'($urandom_range(0, 6));
         ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 8)) : -1;
         gen(rand_instr(c), pick_dly(), pick_dly(), rbit(), ab);
      end

      m_cyc = '0;
      m_ret = '0;
      repeat (2) @(posedge clk);
      foreach (sched[k]) begin
         @(negedge clk);
         reset             = sched[k].rst;
         mem_if.imem_ready = sched[k].ir;
         mem_if.dmem_ready = sched[k].dr;
         zero              = sched[k].z;
         mem_if.instr      = sched[k].ins;
         #1;
         check_eq($sformatf("cyc%0d_ctrl", k), {15'h0, obs}, {15'h0, sched[k].exp});
`ifdef PERF_CNT_EN
         check_eq($sformatf("cyc%0d_cyc_cnt", k), 32'(cyc_cnt), m_cyc);
         check_eq($sformatf("cyc%0d_ret_cnt", k), 32'(ret_cnt), m_ret);
`endif
         if (sched[k].rst) begin
            m_cyc = '0;
            m_ret = '0;
         end else begin
            m_cyc = (m_cyc + (sched[k].act ? 32'd1 : 32'd0)) % (32'd1 << CNT_W);
            m_ret = (m_ret + (sched[k].exp[13] ? 32'd1 : 32'd0)) % (32'd1 << CNT_W);
         end
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
